// File: rtl/psram_arb_pkg.sv
// psram_arb_pkg: shared widths, FSM state and arbitration-mode types for the
// PSRAM port arbiter.
package psram_arb_pkg;

    localparam int PSRAM_AW  = 23;
    localparam int PSRAM_DW  = 16;
    localparam int PSRAM_BLW = 11;

    // Port index width covers the 2..8 supported requesters.
    localparam int ARB_IDXW = 3;
    // Width of one per-port grant counter.
    localparam int ARB_CNTW = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

endpackage

// File: rtl/arb_rr_picker.sv
// arb_rr_picker: combinational winner selection. The request vector is rotated
// so the search start lands at bit 0, the lowest set bit is found, and the
// offset is rotated back to a port index. Fixed-priority mode forces the
// search start to port 0.
module arb_rr_picker
    import psram_arb_pkg::*;
#(
    parameter int NPORTS = 5
) (
    input  logic [NPORTS-1:0]   req_i,
    input  logic [ARB_IDXW-1:0] start_i,
    input  arb_mode_t           mode_i,
    output logic [ARB_IDXW-1:0] idx_o,
    output logic                valid_o
);

    logic [ARB_IDXW-1:0] base;
    logic [2*NPORTS-1:0] dbl;
    logic [NPORTS-1:0]   rot;
    logic [ARB_IDXW-1:0] off;
    logic [ARB_IDXW:0]   sum;

    // Rotate, find first set, rotate back (modulo NPORTS).
    always_comb begin
        base    = (mode_i == ARB_RR) ? start_i : '0;
        dbl     = {req_i, req_i} >> base;
        rot     = dbl[NPORTS-1:0];
        valid_o = |req_i;
        off     = '0;
        // Descending scan so the lowest set bit is the last one written.
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (rot[i]) off = ARB_IDXW'(i);
        end
        sum = {1'b0, off} + {1'b0, base};
        if (sum >= (ARB_IDXW+1)'(NPORTS)) sum = sum - (ARB_IDXW+1)'(NPORTS);
        idx_o = sum[ARB_IDXW-1:0];
    end

endmodule

// File: rtl/psram_port_arbiter.sv
// psram_port_arbiter: N-port arbiter in front of the single-port PSRAM burst
// controller. One burst at a time: IDLE picks a winner, GRANT latches its
// request fields, BUSY routes the controller strobes back to the winner, and
// RELEASE gives the finished port a cycle to drop its request.
// Optional feature: define PSRAM_ARB_STATS_EN to build saturating per-port
// grant counters on grantCnt; otherwise grantCnt is tied to zero.
module psram_port_arbiter
    import psram_arb_pkg::*;
#(
    parameter int NPORTS  = 5,
    parameter int AW      = PSRAM_AW,
    parameter int DW      = PSRAM_DW,
    parameter int BLW     = PSRAM_BLW,
    parameter int RR_MODE = 0
) (
    input  logic                     xClk,
    input  logic                     reset_n,
    input  logic [NPORTS-1:0]        pReq,
    input  logic [NPORTS-1:0]        pRnW,
    input  logic [NPORTS*AW-1:0]     pAddr,
    input  logic [NPORTS*DW-1:0]     pDin,
    input  logic [NPORTS*BLW-1:0]    pBurstLen,
    output logic [NPORTS-1:0]        pWriteNext,
    output logic [NPORTS-1:0]        pDone,
    output logic [NPORTS-1:0]        pDoutValid,
    input  logic                     mReady,
    output logic                     mRequest,
    output logic                     mRnW,
    output logic [AW-1:0]            mAddr,
    output logic [DW-1:0]            mDin,
    output logic [BLW-1:0]           mBurstLen,
    input  logic                     mWriteNext,
    input  logic                     mDone,
    input  logic                     mDoutValid,
    output logic [ARB_IDXW-1:0]      grantIdx,
    output logic [NPORTS*ARB_CNTW-1:0] grantCnt
);

    localparam arb_mode_t MODE = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

    arb_state_t          state_q, state_d;
    logic [ARB_IDXW-1:0] grant_q, grant_d;
    logic [ARB_IDXW-1:0] ptr_q,   ptr_d;
    logic                mreq_q,  mreq_d;
    logic                rnw_q,   rnw_d;
    logic [AW-1:0]       addr_q,  addr_d;
    logic [BLW-1:0]      blen_q,  blen_d;

    logic [ARB_IDXW-1:0] win_idx;
    logic                win_vld;
    logic [ARB_IDXW-1:0] next_ptr;
    logic                take;
    logic                busy;
    int                  gsel;

    arb_rr_picker #(
        .NPORTS (NPORTS)
    ) u_pick (
        .req_i   (pReq),
        .start_i (ptr_q),
        .mode_i  (MODE),
        .idx_o   (win_idx),
        .valid_o (win_vld)
    );

    assign take     = (state_q == IDLE) && mReady && win_vld;
    assign busy     = (state_q == BUSY);
    assign gsel     = int'(grant_q);
    assign next_ptr = (win_idx == ARB_IDXW'(NPORTS - 1)) ? '0 : win_idx + 1'b1;

    // Next-state and request-latch logic for the grant FSM.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        mreq_d  = mreq_q;
        rnw_d   = rnw_q;
        addr_d  = addr_q;
        blen_d  = blen_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    grant_d = win_idx;
                    ptr_d   = next_ptr;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Winner from the IDLE decision stands even if pReq moved.
                rnw_d   = pRnW[grant_q];
                addr_d  = pAddr[gsel*AW +: AW];
                blen_d  = pBurstLen[gsel*BLW +: BLW];
                mreq_d  = 1'b1;
                state_d = BUSY;
            end
            BUSY: begin
                if (mDone) begin
                    mreq_d  = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM and latched downstream request registers.
    always_ff @(posedge xClk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            mreq_q  <= 1'b0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            blen_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            mreq_q  <= mreq_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            blen_q  <= blen_d;
        end
    end

    // Route controller strobes to the granted port only while a burst is live.
    always_comb begin
        pWriteNext = '0;
        pDone      = '0;
        pDoutValid = '0;
        if (busy) begin
            pWriteNext[grant_q] = mWriteNext;
            pDone[grant_q]      = mDone;
            pDoutValid[grant_q] = mDoutValid;
        end
    end

    // mRequest drops in the mDone cycle so the controller never sees a re-request.
    assign mRequest  = mreq_q & ~(busy & mDone);
    assign mRnW      = rnw_q;
    assign mAddr     = addr_q;
    assign mBurstLen = blen_q;
    assign mDin      = pDin[gsel*DW +: DW];
    assign grantIdx  = grant_q;

`ifdef PSRAM_ARB_STATS_EN
    logic [NPORTS-1:0][ARB_CNTW-1:0] cnt_q;

    // Saturating per-port grant counters, bumped at the IDLE decision.
    always_ff @(posedge xClk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (take && (cnt_q[win_idx] != {ARB_CNTW{1'b1}})) begin
            cnt_q[win_idx] <= cnt_q[win_idx] + 1'b1;
        end
    end

    assign grantCnt = cnt_q;
`else
    assign grantCnt = '0;
`endif

endmodule
